seven_seg_scanner: RTL and testbench

Parametrised N-digit multiplexed seven-segment driver. It replaces the fixed two-digit decode, mux and divider chain with one block. It takes a packed hex value and scans DIGITS common-anode/cathode digits, with tear-free double-buffered loading, per-digit blanking, leading-zero suppression, decimal points, 4-bit PWM brightness and anti-ghost dead time. It sits between display-select logic and the board pins.

---
 rtl/seven_seg_scanner.sv | 161 ++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Multiplexed N-digit seven-segment scanner with double-buffered loading,
// blanking, leading-zero suppression, decimal points, PWM brightness and dead time.
module seven_seg_scanner #(
    parameter int DIGITS           = 4,
    parameter int SCAN_DIV         = 12000,
    parameter int DEAD             = 16,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit ANODE_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_en,
    input  logic [3:0]            brightness,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     anode,
    output logic                  frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]     SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]     DEAD_END   = CW'(DEAD);
    localparam logic [DW-1:0]     DIGIT_LAST = DW'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF    = {7{SEG_ACTIVE_LOW}};
    localparam logic              DP_OFF     = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] ANODE_OFF  = {DIGITS{ANODE_ACTIVE_LOW}};

    logic [CW-1:0]       r_slot_cnt;
    logic [DW-1:0]       r_digit;
    logic [4*DIGITS-1:0] r_sh_value,  r_act_value;
    logic [DIGITS-1:0]   r_sh_dp,     r_act_dp;
    logic [DIGITS-1:0]   r_sh_blank,  r_act_blank;
    logic                r_frame_tick;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_anode;

    logic                w_slot_wrap;
    logic                w_frame_end;
    logic [3:0]          w_nibble;
    logic [6:0]          w_glyph;
    logic [DIGITS-1:0]   w_onehot;
    logic [DIGITS-1:0]   w_lz_dark;
    logic                w_upper_zero;
    logic                w_dark;

    // Active-high pattern, bit 0 = segment a, bit 6 = segment g.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: hex_glyph = 7'b0111111;
            4'h1: hex_glyph = 7'b0000110;
            4'h2: hex_glyph = 7'b1011011;
            4'h3: hex_glyph = 7'b1001111;
            4'h4: hex_glyph = 7'b1100110;
            4'h5: hex_glyph = 7'b1101101;
            4'h6: hex_glyph = 7'b1111101;
            4'h7: hex_glyph = 7'b0000111;
            4'h8: hex_glyph = 7'b1111111;
            4'h9: hex_glyph = 7'b1101111;
            4'hA: hex_glyph = 7'b1110111;
            4'hB: hex_glyph = 7'b1111100;
            4'hC: hex_glyph = 7'b0111001;
            4'hD: hex_glyph = 7'b1011110;
            4'hE: hex_glyph = 7'b1111001;
            default: hex_glyph = 7'b1110001;
        endcase
    endfunction

    assign w_slot_wrap = (r_slot_cnt == SLOT_LAST);
    assign w_frame_end = w_slot_wrap && (r_digit == DIGIT_LAST);

    // NOTE: sequential state always uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_cnt <= '0;
            r_digit    <= '0;
        end else if (w_slot_wrap) begin
            r_slot_cnt <= '0;
            r_digit    <= w_frame_end ? '0 : r_digit + 1'b1;
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    // NOTE: shadow/active are reset, not left X, because blanking and
    // leading-zero logic read them on the very first slot after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_value   <= '0;
            r_sh_dp      <= '0;
            r_sh_blank   <= '0;
            r_act_value  <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            if (load) begin
                r_sh_value <= value;
                r_sh_dp    <= dp_in;
                r_sh_blank <= blank_in;
            end
            // Display contents only change between frames, so no digit tears.
            if (w_frame_end) begin
                r_act_value <= load ? value    : r_sh_value;
                r_act_dp    <= load ? dp_in    : r_sh_dp;
                r_act_blank <= load ? blank_in : r_sh_blank;
            end
            r_frame_tick <= w_frame_end;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_upper_zero = 1'b1;
        w_lz_dark    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_upper_zero = w_upper_zero & (r_act_value[4*i +: 4] == 4'h0);
            if (i != 0) begin
                w_lz_dark[i] = w_upper_zero;
            end
        end
    end

    assign w_nibble = r_act_value[4*r_digit +: 4];
    assign w_glyph  = hex_glyph(w_nibble);
    assign w_onehot = DIGITS'(1) << r_digit;

    // brightness=0 makes the last term always true, so the display stays dark.
    assign w_dark = r_act_blank[r_digit]
                  | (lz_en & w_lz_dark[r_digit])
                  | (r_slot_cnt < DEAD_END)
                  | (r_slot_cnt[3:0] >= brightness);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg   <= SEG_OFF;
            r_dp    <= DP_OFF;
            r_anode <= ANODE_OFF;
        end else if (w_dark) begin
            r_seg   <= SEG_OFF;
            r_dp    <= DP_OFF;
            r_anode <= ANODE_OFF;
        end else begin
            r_seg   <= w_glyph ^ SEG_OFF;
            r_dp    <= r_act_dp[r_digit] ^ DP_OFF;
            r_anode <= w_onehot ^ ANODE_OFF;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign anode      = r_anode;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: directed scenarios plus random
// stimulus, all compared against a frame/slot arithmetic reference model.
module tb_seven_seg_scanner;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 64;
    localparam int DEAD     = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    // Active-high glyphs g..a, straight from the hex table.
    localparam logic [6:0] GLYPH [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_en;
    logic [3:0]  brightness;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  anode;
    logic        frame_tick;

    seven_seg_scanner #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD(DEAD),
        .SEG_ACTIVE_LOW(1'b1), .ANODE_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in),
        .blank_in(blank_in), .lz_en(lz_en), .brightness(brightness),
        .seg(seg), .dp(dp), .anode(anode), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: position in the scan is just elapsed cycles mod FRAME.
    int          cyc;
    int          last_pos;
    logic [15:0] sh_val, act_val;
    logic [3:0]  sh_dp, act_dp, sh_bl, act_bl;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_tick;

    int n_on, n_tick, n_dead_on, n_dp_lit, n_dp_bad;
    int n_dig_on [DIGITS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc      = 0;
        last_pos = -1;
        sh_val   = '0; act_val = '0;
        sh_dp    = '0; act_dp  = '0;
        sh_bl    = '0; act_bl  = '0;
        e_seg    = 7'h7F;
        e_dp     = 1'b1;
        e_an     = '0;
        e_tick   = 1'b0;
    endtask

    task automatic clear_stats();
        n_on = 0; n_tick = 0; n_dead_on = 0; n_dp_lit = 0; n_dp_bad = 0;
        for (int d = 0; d < DIGITS; d++) n_dig_on[d] = 0;
    endtask

    // Inputs are set by the caller right after a negedge; this predicts the
    // outputs after the coming posedge, advances the model, then compares.
    task automatic cycle();
        int   slot, dig;
        bit   lit;
        logic [3:0] nib;
        if (rst) begin
            model_reset();
        end else begin
            slot = cyc % SCAN_DIV;
            dig  = (cyc / SCAN_DIV) % DIGITS;
            nib  = act_val[4*dig +: 4];
            lit  = !act_bl[dig] && (slot >= DEAD) && ((slot % 16) < int'(brightness));
            if (lz_en && dig != 0 && (act_val >> (4*dig)) == 16'h0) lit = 0;
            e_seg  = lit ? ~GLYPH[nib] : 7'h7F;
            e_dp   = lit ? ~act_dp[dig] : 1'b1;
            e_an   = lit ? 4'(1 << dig) : 4'b0000;
            e_tick = (cyc % FRAME) == FRAME - 1;
            if (e_tick) begin
                act_val = load ? value    : sh_val;
                act_dp  = load ? dp_in    : sh_dp;
                act_bl  = load ? blank_in : sh_bl;
            end
            if (load) begin
                sh_val = value; sh_dp = dp_in; sh_bl = blank_in;
            end
            last_pos = cyc % FRAME;
            cyc++;
        end
        @(negedge clk);
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("anode", 32'(anode), 32'(e_an));
        check("frame_tick", 32'(frame_tick), 32'(e_tick));
        check("onehot", 32'($countones(anode) <= 1), 32'd1);
        if (anode != 4'b0000) begin
            n_on++;
            if (last_pos % SCAN_DIV < DEAD) n_dead_on++;
            for (int d = 0; d < DIGITS; d++) if (anode == 4'(1 << d)) n_dig_on[d]++;
        end
        if (frame_tick) n_tick++;
        if (dp == 1'b0) begin
            n_dp_lit++;
            if (anode != 4'b0001) n_dp_bad++;
        end
    endtask

    // Runs until the cycle at frame position pos has been clocked; at most one frame.
    task automatic run_to(input int pos);
        for (int k = 0; k < FRAME; k++) begin
            cycle();
            if (last_pos == pos) break;
        end
        check("run_to_pos", 32'(last_pos), 32'(pos));
    endtask

    task automatic load_now(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v; dp_in = d; blank_in = b; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    initial begin
        int first_pos;
        logic [3:0] first_an;
        logic [6:0] first_seg;

        rst = 1'b1; value = '0; load = 1'b0; dp_in = '0; blank_in = '0;
        lz_en = 1'b0; brightness = 4'd15;
        model_reset();
        clear_stats();
        @(negedge clk);
        cycle();
        cycle();
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_anode", 32'(anode), 32'h0);
        rst = 1'b0;

        // Basic scan of 12AF after the first frame boundary.
        load_now(16'h12AF, 4'b0000, 4'b0000);
        run_to(FRAME - 1);
        clear_stats();
        run_to(5);
        check("d0_seg_F", 32'(seg), 32'(7'b0001110));
        check("d0_anode", 32'(anode), 32'(4'b0001));
        run_to(3*SCAN_DIV + 5);
        check("d3_seg_1", 32'(seg), 32'(7'b1111001));
        check("d3_anode", 32'(anode), 32'(4'b1000));
        run_to(FRAME - 1);
        check("dead_time_dark", 32'(n_dead_on), 32'd0);

        // Mid-frame load waits for the boundary; boundary-cycle load lands at once.
        run_to(SCAN_DIV + 9);
        load_now(16'h8888, 4'b0000, 4'b0000);
        run_to(SCAN_DIV + 20);
        check("midload_old_d1", 32'(seg), 32'(7'b0001000));
        run_to(3*SCAN_DIV + 5);
        check("midload_old_d3", 32'(seg), 32'(7'b1111001));
        run_to(SCAN_DIV + 5);
        check("midload_new_d1", 32'(seg), 32'(7'b0000000));
        run_to(FRAME - 2);
        load_now(16'h3456, 4'b0000, 4'b0000);
        run_to(5);
        check("boundary_load_d0", 32'(seg), 32'(7'b0000010));

        // Leading-zero suppression.
        lz_en = 1'b1;
        load_now(16'h0070, 4'b0000, 4'b0000);
        run_to(FRAME - 1);
        clear_stats();
        run_to(5);
        check("lz_d0_zero", 32'(seg), 32'(7'b1000000));
        run_to(SCAN_DIV + 5);
        check("lz_d1_seven", 32'(seg), 32'(7'b1111000));
        run_to(FRAME - 1);
        check("lz_d3_dark", 32'(n_dig_on[3]), 32'd0);
        check("lz_d2_dark", 32'(n_dig_on[2]), 32'd0);
        check("lz_d1_lit", 32'(n_dig_on[1]), 32'd56);
        check("lz_d0_lit", 32'(n_dig_on[0]), 32'd56);
        load_now(16'h0000, 4'b0000, 4'b0000);
        run_to(FRAME - 1);
        clear_stats();
        run_to(5);
        check("lz0_d0_seg", 32'(seg), 32'(7'b1000000));
        check("lz0_d0_anode", 32'(anode), 32'(4'b0001));
        run_to(FRAME - 1);
        check("lz0_only_d0", 32'(n_on), 32'd56);
        check("lz0_d0_count", 32'(n_dig_on[0]), 32'd56);

        // PWM brightness.
        lz_en = 1'b0;
        brightness = 4'd4;
        load_now(16'h1234, 4'b0000, 4'b0000);
        run_to(FRAME - 1);
        clear_stats();
        run_to(SCAN_DIV - 1);
        check("bright4_slot", 32'(n_on), 32'd12);
        run_to(FRAME - 1);
        check("bright4_frame", 32'(n_on), 32'd48);
        brightness = 4'd0;
        clear_stats();
        run_to(FRAME - 1);
        check("bright0_dark", 32'(n_on), 32'd0);

        // Blanking, decimal point and frame tick rate.
        brightness = 4'd15;
        load_now(16'h1234, 4'b0001, 4'b0010);
        run_to(FRAME - 1);
        clear_stats();
        run_to(FRAME - 1);
        check("blank_d1", 32'(n_dig_on[1]), 32'd0);
        check("dp_only_d0", 32'(n_dp_bad), 32'd0);
        check("dp_lit_count", 32'(n_dp_lit), 32'd56);
        check("tick_per_frame", 32'(n_tick), 32'd1);

        // Asynchronous reset mid-slot on digit 2.
        load_now(16'h4321, 4'b0000, 4'b0000);
        run_to(FRAME - 1);
        run_to(2*SCAN_DIV + 30);
        check("pre_rst_anode", 32'(anode), 32'(4'b0100));
        #2 rst = 1'b1;
        #1;
        check("async_rst_seg", 32'(seg), 32'h7F);
        check("async_rst_dp", 32'(dp), 32'd1);
        check("async_rst_anode", 32'(anode), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        first_pos = -1; first_an = '0; first_seg = '0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (anode != 4'b0000 && first_pos < 0) begin
                first_pos = last_pos; first_an = anode; first_seg = seg;
            end
        end
        check("post_rst_first_pos", 32'(first_pos), 32'd4);
        check("post_rst_first_anode", 32'(first_an), 32'(4'b0001));
        check("post_rst_active_zero", 32'(first_seg), 32'(7'b1000000));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            v = v & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            value    = v;
            dp_in    = 4'($urandom);
            blank_in = 4'($urandom) & 4'($urandom) & 4'($urandom);
            load     = ($urandom_range(0, 49) == 0);
            if (i % 97 == 0) begin
                lz_en      = 1'($urandom);
                brightness = 4'($urandom_range(0, 15));
            end
            cycle();
        end
        load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
